// File: rtl/pwm_breath_ctrl.sv
// Breathing-pattern duty sequencer feeding a PWM block: triangular ramp with top/bottom dwell.
// Latency: one clock from en/tick to the registered outputs; first ramp step STEP_DIV clocks after entering RISE.
// Backpressure: none; the sequencer free-runs while en is high and the inputs are sampled only on tick cycles.
module pwm_breath_ctrl #(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 50000,
  parameter int HOLD_W   = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  step_size,
  input  logic [HOLD_W-1:0] hold_hi,
  input  logic [HOLD_W-1:0] hold_lo,
  output logic [WIDTH-1:0]  duty_cycle,
  output logic              pwm_en,
  output logic [2:0]        phase,
  output logic              cycle_done
);

  localparam int PW = $clog2(STEP_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(STEP_DIV - 1);
  localparam logic [WIDTH-1:0] DUTY_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      pre, pre_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [WIDTH-1:0]   duty_nxt;
  logic               done_nxt;
  logic [WIDTH-1:0]   step;
  logic [WIDTH:0]     sum;
  logic [HOLD_W:0]    hold_inc;
  logic               tick;

  assign phase = state;

  // State, counters and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pre        <= '0;
      hold_cnt   <= '0;
      duty_cycle <= '0;
      pwm_en     <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      pre        <= pre_nxt;
      hold_cnt   <= hold_nxt;
      duty_cycle <= duty_nxt;
      pwm_en     <= (state_nxt != IDLE);
      cycle_done <= done_nxt;
    end
  end

  // Next-state logic: en low wins over everything, otherwise ramp/hold advance only on tick.
  always_comb begin
    step      = (step_size == '0) ? WIDTH'(1) : step_size;
    sum       = {1'b0, duty_cycle} + {1'b0, step};
    hold_inc  = {1'b0, hold_cnt} + (HOLD_W+1)'(1);
    tick      = (pre == PRE_LAST);
    state_nxt = state;
    pre_nxt   = pre;
    hold_nxt  = hold_cnt;
    duty_nxt  = duty_cycle;
    done_nxt  = 1'b0;

    if (!en) begin
      state_nxt = IDLE;
      pre_nxt   = '0;
      hold_nxt  = '0;
      duty_nxt  = '0;
    end else if (state == IDLE) begin
      // Every run starts fresh from zero duty; there is no resume.
      state_nxt = RISE;
      pre_nxt   = '0;
      hold_nxt  = '0;
      duty_nxt  = '0;
    end else begin
      pre_nxt = tick ? '0 : pre + PW'(1);
      if (tick) begin
        case (state)
          RISE: begin
            if (sum >= {1'b0, DUTY_MAX}) begin
              duty_nxt = DUTY_MAX;
              hold_nxt = '0;
              state_nxt = (hold_hi != '0) ? HOLD_HI : FALL;
            end else begin
              duty_nxt = sum[WIDTH-1:0];
            end
          end
          HOLD_HI: begin
            // Comparing with >= keeps a hold that was shortened mid-dwell from overrunning.
            if (hold_inc >= {1'b0, hold_hi}) begin
              hold_nxt  = '0;
              state_nxt = FALL;
            end else begin
              hold_nxt = hold_inc[HOLD_W-1:0];
            end
          end
          FALL: begin
            if (duty_cycle <= step) begin
              duty_nxt = '0;
              hold_nxt = '0;
              if (hold_lo != '0) begin
                state_nxt = HOLD_LO;
              end else begin
                state_nxt = RISE;
                done_nxt  = 1'b1;
              end
            end else begin
              duty_nxt = duty_cycle - step;
            end
          end
          HOLD_LO: begin
            if (hold_inc >= {1'b0, hold_lo}) begin
              hold_nxt  = '0;
              state_nxt = RISE;
              done_nxt  = 1'b1;
            end else begin
              hold_nxt = hold_inc[HOLD_W-1:0];
            end
          end
          default: begin
            state_nxt = IDLE;
            duty_nxt  = '0;
            pre_nxt   = '0;
            hold_nxt  = '0;
          end
        endcase
      end
    end
  end

endmodule
